// File: rtl/bt_link_scheduler.sv
// Round-robin scheduler muxing NUM_REQ 32-bit producers onto one link, with a header word per
// burst, a burst-length cap and a stall watchdog. Define BT_SCHED_PRIORITY_EN for strict priority on requester 0.

module bt_sched_lane (
  input  logic        sel_i,
  input  logic        vld_i,
  input  logic        last_i,
  input  logic [31:0] data_i,
  input  logic        bt_ready_i,
  output logic        rdy_o,
  output logic        vld_o,
  output logic        last_o,
  output logic [31:0] data_o
);
  // A lane that is not selected contributes zeros, so the top can OR-reduce all lanes.
  assign rdy_o  = sel_i & bt_ready_i;
  assign vld_o  = sel_i & vld_i;
  assign last_o = sel_i & last_i;
  assign data_o = sel_i ? data_i : 32'h0;
endmodule

module bt_link_scheduler #(
  parameter int NUM_REQ   = 3,
  parameter int MAX_BURST = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [32*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [31:0]          bt_data,
  output logic                 bt_valid,
  input  logic                 bt_ready,
  output logic [3:0]           grant_id,
  output logic                 busy,
  output logic                 timeout_err
);
  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_BURST} state_t;

  state_t      state_q, state_d;
  logic [3:0]  rr_q, rr_d;
  logic [3:0]  grant_q, grant_d;
  logic [15:0] seq_q, seq_d;
  logic [7:0]  wc_q, wc_d;
  logic [15:0] sc_q, sc_d;
  logic        tmo_q, tmo_d;

  logic [NUM_REQ-1:0]         lane_sel, lane_vld, lane_last;
  logic [NUM_REQ-1:0][31:0]   lane_data;
  logic                       pay_vld, pay_last;
  logic [31:0]                pay_data;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane_sel[i] = (state_q == S_BURST) && (grant_q == 4'(i));
    bt_sched_lane u_lane (
      .sel_i      (lane_sel[i]),
      .vld_i      (req_valid[i]),
      .last_i     (req_last[i]),
      .data_i     (req_data[32*i +: 32]),
      .bt_ready_i (bt_ready),
      .rdy_o      (req_ready[i]),
      .vld_o      (lane_vld[i]),
      .last_o     (lane_last[i]),
      .data_o     (lane_data[i])
    );
  end

  always_comb begin
    pay_vld  = 1'b0;
    pay_last = 1'b0;
    pay_data = 32'h0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pay_vld  = pay_vld  | lane_vld[i];
      pay_last = pay_last | lane_last[i];
      pay_data = pay_data | lane_data[i];
    end
  end

  // Arbitration: smallest cyclic distance after rr_q wins.
  logic [3:0] pick;
  logic       found;
  int         arb_best, arb_d;

  always_comb begin
    pick     = grant_q;
    found    = 1'b0;
    arb_best = NUM_REQ;
    arb_d    = 0;
`ifdef BT_SCHED_PRIORITY_EN
    if (req_valid[0]) begin
      pick  = 4'd0;
      found = 1'b1;
    end else begin
      for (int j = 1; j < NUM_REQ; j++) begin
        arb_d = j - int'(rr_q) - 1;
        if (arb_d < 0) arb_d = arb_d + NUM_REQ - 1;
        if (req_valid[j] && arb_d < arb_best) begin
          arb_best = arb_d;
          pick     = 4'(j);
          found    = 1'b1;
        end
      end
    end
`else
    for (int j = 0; j < NUM_REQ; j++) begin
      arb_d = j - int'(rr_q) - 1;
      if (arb_d < 0) arb_d = arb_d + NUM_REQ;
      if (req_valid[j] && arb_d < arb_best) begin
        arb_best = arb_d;
        pick     = 4'(j);
        found    = 1'b1;
      end
    end
`endif
  end

  logic [8:0]  wc_inc;
  logic [16:0] sc_inc;
  logic        xfer;
  assign wc_inc = {1'b0, wc_q} + 9'd1;
  assign sc_inc = {1'b0, sc_q} + 17'd1;
  assign xfer   = bt_valid & bt_ready;

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    grant_d  = grant_q;
    seq_d    = seq_q;
    wc_d     = wc_q;
    sc_d     = sc_q;
    tmo_d    = 1'b0;
    bt_valid = 1'b0;
    bt_data  = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = pick;
`ifdef BT_SCHED_PRIORITY_EN
          if (pick != 4'd0) rr_d = pick;
`else
          rr_d    = pick;
`endif
          sc_d    = 16'h0;
          state_d = S_HEADER;
        end
      end
      S_HEADER: begin
        bt_valid = 1'b1;
        bt_data  = {8'hA5, 4'h0, grant_q, seq_q};
        if (bt_ready) begin
          seq_d   = seq_q + 16'd1;
          wc_d    = 8'h0;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        bt_valid = pay_vld;
        bt_data  = pay_data;
        if (pay_vld && bt_ready) begin
          wc_d = wc_inc[7:0];
          if (pay_last || wc_inc == 9'(MAX_BURST)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Watchdog shared by HEADER and BURST; an aborted header never bumps seq.
    if (state_q != S_IDLE) begin
      if (xfer) begin
        sc_d = 16'h0;
      end else if (sc_inc == 17'(TIMEOUT)) begin
        sc_d    = 16'h0;
        tmo_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        sc_d = sc_inc[15:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      rr_q    <= 4'(NUM_REQ - 1);
      grant_q <= 4'h0;
      seq_q   <= 16'h0;
      wc_q    <= 8'h0;
      sc_q    <= 16'h0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      seq_q   <= seq_d;
      wc_q    <= wc_d;
      sc_q    <= sc_d;
      tmo_q   <= tmo_d;
    end
  end

  assign grant_id    = grant_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = tmo_q;
endmodule

// File: tb/tb_bt_link_scheduler.sv
// Scoreboard bench for bt_link_scheduler: stimulus pushes expected link words, a negedge monitor pops and compares.
module tb_bt_link_scheduler;
  localparam int N = 3;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [32*N-1:0] req_data;
  logic [31:0]     bt_data;
  logic            bt_valid, bt_ready;
  logic [3:0]      grant_id;
  logic            busy, timeout_err;

  always #5 clk = ~clk;

  bt_link_scheduler #(.NUM_REQ(N), .MAX_BURST(8), .TIMEOUT(255)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .bt_data(bt_data), .bt_valid(bt_valid),
    .bt_ready(bt_ready), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  int          total = 0, bad = 0;
  int          cyc = 0, xfer_cnt = 0, tmo_cnt = 0, tmo_cyc = 0;
  logic        seen_idle = 1'b1;
  logic [15:0] tb_seq = 16'h0;
  logic [32:0] expq[$];
  logic [32:0] rq[N][$];
  logic [N-1:0] acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dw(input int i, input int k);
    return (32'(i) << 24) | 32'h0050_0000 | 32'(k);
  endfunction

  function automatic logic [31:0] hw(input int id, input logic [15:0] s);
    return {8'hA5, 4'h0, 4'(id), s};
  endfunction

  task automatic load(input int i, input int n, input int k0);
    for (int j = 0; j < n; j++) rq[i].push_back({(j == n - 1), dw(i, k0 + j)});
  endtask

  task automatic exp_burst(input int i, input int n, input int k0);
    expq.push_back({1'b1, hw(i, tb_seq)});
    tb_seq = tb_seq + 16'd1;
    for (int j = 0; j < n; j++) expq.push_back({1'b0, dw(i, k0 + j)});
  endtask

  task automatic sync_neg();
    @(negedge clk); #1;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((expq.size() != 0 || busy) && n < limit) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_left", 32'(expq.size()), 32'd0);
  endtask

  task automatic wait_xfer(input int target, input int limit);
    int n = 0;
    while (xfer_cnt < target && n < limit) begin
      @(posedge clk); #1; n++;
    end
    chk("wait_xfer", 32'(xfer_cnt >= target), 32'd1);
  endtask

  // Requester model: word at head of each queue is offered; popped after a handshake.
  initial begin
    req_valid = '0; req_last = '0; req_data = '0; acc = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        logic [32:0] w;
        if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          w = rq[i][0];
          req_valid[i] = 1'b1;
          req_last[i]  = w[32];
          req_data[32*i +: 32] = w[31:0];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
          req_data[32*i +: 32] = 32'h0;
        end
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    forever begin
      logic [32:0] e;
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        seen_idle = 1'b1;
        continue;
      end
      if (!busy) seen_idle = 1'b1;
      if (timeout_err) begin
        tmo_cnt++;
        tmo_cyc = cyc;
        chk("tmo_with_idle", 32'(busy), 32'd0);
      end
      if (bt_valid && bt_ready) begin
        xfer_cnt++;
        if (expq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_word: got %h want none", bt_data);
        end else begin
          e = expq.pop_front();
          chk(e[32] ? "hdr_word" : "pay_word", bt_data, e[31:0]);
          if (e[32]) chk("idle_before_hdr", 32'(seen_idle), 32'd1);
          else seen_idle = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int base, en_cyc;
    bt_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_bt_valid", 32'(bt_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_tmo", 32'(timeout_err), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1; reset_n = 1'b1;

    // Round-robin fairness
    sync_neg();
    load(0, 2, 0); load(1, 2, 0); load(2, 2, 0); load(0, 2, 2);
`ifdef BT_SCHED_PRIORITY_EN
    exp_burst(0, 2, 0); exp_burst(0, 2, 2); exp_burst(1, 2, 0); exp_burst(2, 2, 0);
`else
    exp_burst(0, 2, 0); exp_burst(1, 2, 0); exp_burst(2, 2, 0); exp_burst(0, 2, 2);
`endif
    drain(200);

    // Burst cap: 20 words -> 8, 8, 4
    sync_neg();
    load(1, 20, 0);
    exp_burst(1, 8, 0); exp_burst(1, 8, 8); exp_burst(1, 4, 16);
    drain(200);

    // Link backpressure mid-burst
    sync_neg();
    base = xfer_cnt;
    load(2, 8, 0);
    exp_burst(2, 8, 0);
    wait_xfer(base + 3, 100);
    bt_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_data_hold", bt_data, dw(2, 2));
      chk("bp_valid", 32'(bt_valid), 32'd1);
    end
    chk("bp_no_tmo", 32'(tmo_cnt), 32'd0);
    @(posedge clk); #1; bt_ready = 1'b1;
    drain(200);

    // Watchdog in HEADER
    sync_neg();
    bt_ready = 1'b0;
    load(0, 2, 0);
    en_cyc = cyc;
    exp_burst(0, 2, 0);
    repeat (300) @(posedge clk);
    #1;
    chk("wd_pulses", 32'(tmo_cnt), 32'd1);
    chk("wd_pulse_cycle", 32'(tmo_cyc - en_cyc), 32'd257);
    bt_ready = 1'b1;
    drain(200);
    chk("wd_pulses_after", 32'(tmo_cnt), 32'd1);

    // Reset mid-burst
    sync_neg();
    base = xfer_cnt;
    load(1, 8, 0);
    expq.push_back({1'b1, hw(1, tb_seq)});
    for (int j = 0; j < 3; j++) expq.push_back({1'b0, dw(1, j)});
    wait_xfer(base + 4, 100);
    reset_n = 1'b0;
    #1;
    chk("mr_bt_valid", 32'(bt_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_grant", 32'(grant_id), 32'd0);
    chk("mr_req_ready", 32'(req_ready), 32'd0);
    chk("mr_exp_left", 32'(expq.size()), 32'd0);
    @(negedge clk); #1;
    rq[1].delete();
    tb_seq = 16'h0;
    @(posedge clk); #1; reset_n = 1'b1;
    sync_neg();
    load(2, 1, 0);
    exp_burst(2, 1, 0);
    drain(100);

    // Requesters 0 and 2 continuously valid
    sync_neg();
    for (int m = 0; m < 3; m++) begin
      load(0, 1, 10 + m);
      load(2, 1, 10 + m);
    end
`ifdef BT_SCHED_PRIORITY_EN
    for (int m = 0; m < 3; m++) exp_burst(0, 1, 10 + m);
    for (int m = 0; m < 3; m++) exp_burst(2, 1, 10 + m);
`else
    for (int m = 0; m < 3; m++) begin
      exp_burst(0, 1, 10 + m);
      exp_burst(2, 1, 10 + m);
    end
`endif
    drain(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
